fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 14 +
 rtl/fetch_ctrl_retire_counter.sv | 21 ++
 rtl/fetch_ctrl.sv | 76 +++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM states,
// address/instruction widths and the default reset PC.
package fetch_ctrl_pkg;
  localparam int ADDR_W = 30;
  localparam int INST_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 30'h0000_0C00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_e;
endpackage

// File: rtl/fetch_ctrl_retire_counter.sv
// Free-running count of retired instructions; wraps silently at 2^32.
module fetch_ctrl_retire_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [31:0] cnt_o
);
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = en_i ? cnt_q + 32'd1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller: fetch at pc, hold the
// word for decode until retired, then advance to next_pc or halt.
module fetch_ctrl #(
  parameter int ADDR_W = fetch_ctrl_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = fetch_ctrl_pkg::RESET_PC_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic [ADDR_W-1:0]                 pc,
  input  logic [ADDR_W-1:0]                 next_pc,
  output logic                              imem_req,
  output logic [ADDR_W-1:0]                 imem_addr,
  input  logic                              imem_ack,
  input  logic [fetch_ctrl_pkg::INST_W-1:0] imem_rdata,
  output logic [fetch_ctrl_pkg::INST_W-1:0] inst,
  output logic                              inst_valid,
  input  logic                              inst_ready,
  input  logic                              halt,
  output logic                              halted,
  output logic [31:0]                       retire_cnt,
  output logic [1:0]                        state_dbg
);
  import fetch_ctrl_pkg::*;

  // Handshakes: a fetch completes on a cycle with imem_req && imem_ack, an
  // instruction retires on a cycle with inst_valid && inst_ready; either
  // strobe is ignored while its partner is low.
  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [INST_W-1:0]   inst_q;
  logic                retire;

  assign retire = (state_q == HOLD) && inst_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      case (state_q)
        IDLE:    state_q <= halt ? HALTED : FETCH;
        FETCH: begin
          // halt is deliberately not looked at here: the request must finish
          if (imem_ack) begin
            inst_q  <= imem_rdata;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            pc_q    <= next_pc;
            state_q <= halt ? HALTED : FETCH;
          end
        end
        HALTED:  state_q <= HALTED;
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_ctrl_retire_counter u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (retire),
    .cnt_o (retire_cnt)
  );

  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign imem_req   = (state_q == FETCH);
  assign inst_valid = (state_q == HOLD);
  assign halted     = (state_q == HALTED);
  assign state_dbg  = state_q;
endmodule
